// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer and its synchronizer.
// Gray-coded states so that state[1] always equals the committed level.
package debounce_pkg;

   typedef enum logic [1:0] {
      LOW       = 2'b00,
      WAIT_HIGH = 2'b01,
      HIGH      = 2'b11,
      WAIT_LOW  = 2'b10
   } state_t;

   localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Latency SYNC_STAGES cycles; synchronous active-high reset clears the chain.
module sync_2ff
   import debounce_pkg::*;
(
   input  logic clk,
   input  logic rstb,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rstb) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous input into a clean registered level plus rise/fall pulses.
// Output changes STABLE_CYCLES+2 edges after a stable input change; shorter glitches are dropped.
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic clk,
   input  logic rstb,
   input  logic d_in,
   output logic q_clean,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic             d_sync;
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             q_clean_q;
   logic             rise_q;
   logic             fall_q;

   sync_2ff u_sync (
      .clk  (clk),
      .rstb (rstb),
      .d    (d_in),
      .q    (d_sync)
   );

   assign cnt_d = cnt_q + CNT_ONE;

   always_ff @(posedge clk) begin
      if (rstb) begin
         state_q   <= LOW;
         cnt_q     <= '0;
         q_clean_q <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         case (state_q)
            LOW: begin
               if (d_sync) begin
                  state_q <= WAIT_HIGH;
                  cnt_q   <= CNT_ONE;
               end
            end
            WAIT_HIGH: begin
               if (!d_sync) begin
                  state_q <= LOW;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q   <= HIGH;
                  cnt_q     <= '0;
                  q_clean_q <= 1'b1;
                  rise_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            HIGH: begin
               if (!d_sync) begin
                  state_q <= WAIT_LOW;
                  cnt_q   <= CNT_ONE;
               end
            end
            WAIT_LOW: begin
               if (d_sync) begin
                  state_q <= HIGH;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q   <= LOW;
                  cnt_q     <= '0;
                  q_clean_q <= 1'b0;
                  fall_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q <= LOW;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign q_clean = q_clean_q;
   assign rise    = rise_q;
   assign fall    = fall_q;

   // Counter saturates at the qualification threshold, so it can never wrap.
   a_cnt_bound: assert property (@(posedge clk) cnt_q <= CNT_MAX);
   a_pulse_excl: assert property (@(posedge clk) !(rise_q && fall_q));

endmodule
